// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_fifo and fetch_stage.
package fetch_pkg;

    localparam int XLEN = 32;

    // Canonical idle instruction (addi x0, x0, 0).
    localparam logic [XLEN-1:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with a registered head output,
// flush, and push/pop in the same cycle at any fill level.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the storage is reset too (it is tiny) so the head output reads zero instead of X.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch unit: issues word fetches, buffers responses with their PCs,
// and hands them to decode; optional stall counter under FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0080,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    output logic            req_o,
    output logic [XLEN-1:0] instr_rdata_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            dec_ready_i,
    input  logic            branch_i,
`ifdef FETCH_PERF_CNT_EN
    input  logic [XLEN-1:0] branch_addr_i,
    output logic [XLEN-1:0] stall_cnt_o
`else
    input  logic [XLEN-1:0] branch_addr_i
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_stage: FIFO_DEPTH must be a power of two in 2..8");
    end

    logic [XLEN-1:0]  fetch_addr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [XLEN-1:0]  pc_queue [FIFO_DEPTH];
    logic [PTR_W-1:0] pcq_wr;
    logic [PTR_W-1:0] pcq_rd;
    logic             fifo_empty;
    logic             fifo_full;
    logic             grant;
    logic             rvalid_ok;
    logic             push;
    logic             pop;
    fetch_entry_t     fifo_din;
    fetch_entry_t     fifo_head;

    // Credit check: a head leaving this cycle frees its slot, which keeps a
    // single-cycle memory streaming at one instruction per cycle.
    // NOTE: defaults come first in every always_comb so no path infers a latch.
    always_comb begin
        pop         = !fifo_empty && dec_ready_i;
        instr_req_o = 1'b0;
        if (!rst_i) begin
            instr_req_o = (int'(fifo_count) + int'(outstanding) - int'(pop)) < FIFO_DEPTH;
        end
    end

    assign grant     = instr_req_o && instr_gnt_i;
    assign rvalid_ok = instr_rvalid_i && (outstanding != '0);
    assign push      = rvalid_ok && (discard == '0) && !branch_i;
    assign fifo_din  = '{pc: pc_queue[pcq_rd], instr: instr_rdata_i};

    assign instr_addr_o  = fetch_addr;
    assign req_o         = !fifo_empty;
    assign instr_rdata_o = fifo_head.instr;
    assign instr_pc_o    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (branch_i),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr  <= BOOT_ADDR;
            outstanding <= '0;
            discard     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rvalid_ok);
            if (grant) begin
                pcq_wr <= pcq_wr + PTR_W'(1);
            end
            if (rvalid_ok) begin
                pcq_rd <= pcq_rd + PTR_W'(1);
            end
            // Every request still in flight after a redirect belongs to the old stream.
            if (branch_i) begin
                fetch_addr <= branch_addr_i & ALIGN_MASK;
                discard    <= outstanding + CNT_W'(grant) - CNT_W'(rvalid_ok);
            end else begin
                if (grant) begin
                    fetch_addr <= fetch_addr + WORD_BYTES;
                end
                if (rvalid_ok && discard != '0) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    // Entries are always written before they are read, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            pc_queue[pcq_wr] <= fetch_addr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall;

    assign stall = (req_o && !dec_ready_i) || (instr_req_o && !instr_gnt_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

    a_rvalid_needs_request: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(instr_rvalid_i && outstanding == '0)
    );

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(push && fifo_full && !pop)
    );

    a_request_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (instr_req_o && !instr_gnt_i && !branch_i) |=>
            (instr_req_o && instr_addr_o == $past(instr_addr_o))
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a queue-based model of the fetch/decode behaviour.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0080;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_rsp_t;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } pending_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = INSTR_NOP;
    logic        ready = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] baddr = '0;
    logic        ireq;
    logic [31:0] iaddr;
    logic        req;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    fetch_stage #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_o    (ireq),
        .instr_addr_o   (iaddr),
        .instr_gnt_i    (gnt),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .req_o          (req),
        .instr_rdata_o  (out_data),
        .instr_pc_o     (out_pc),
        .dec_ready_i    (ready),
        .branch_i       (branch),
`ifdef FETCH_PERF_CNT_EN
        .branch_addr_i  (baddr),
        .stall_cnt_o    (stall_cnt)
`else
        .branch_addr_i  (baddr)
`endif
    );

`ifndef FETCH_PERF_CNT_EN
    assign stall_cnt = '0;
`endif

    // Reference model state.
    mem_rsp_t     mem_q[$];
    pending_t     m_out[$];
    fetch_entry_t m_fifo[$];
    logic [31:0]  m_addr = BOOT;
    logic [31:0]  m_stall = '0;
    logic [31:0]  salt;
    int           cyc = 0;
    int           lat_min = 1;
    int           lat_max = 1;

    // Expected and observed values of the last cycle.
    logic         exp_ireq, exp_req;
    logic [31:0]  exp_addr, exp_stall;
    fetch_entry_t exp_head;
    logic         obs_ireq, obs_req;
    logic [31:0]  obs_addr, obs_data, obs_pc, obs_stall;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h0000_0080) ? 32'h0000_006F : (a ^ salt);
    endfunction

    // One clock: drive memory response, sample outputs at negedge, advance model.
    task automatic cycle();
        bit       pop_now;
        pending_t p;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_q[0].data;
        end else begin
            rvalid = 1'b0;
            rdata  = INSTR_NOP;
        end
        @(negedge clk);
        obs_ireq  = ireq;
        obs_addr  = iaddr;
        obs_req   = req;
        obs_data  = out_data;
        obs_pc    = out_pc;
        obs_stall = stall_cnt;

        exp_req   = (m_fifo.size() != 0);
        exp_head  = exp_req ? m_fifo[0] : '0;
        pop_now   = exp_req && ready;
        exp_ireq  = !rst && ((m_fifo.size() + m_out.size() - (pop_now ? 1 : 0)) < DEPTH);
        exp_addr  = m_addr;
        exp_stall = m_stall;

        if (rst) begin
            m_fifo.delete();
            m_out.delete();
            mem_q.delete();
            m_addr  = BOOT;
            m_stall = '0;
        end else begin
            if (((exp_req && !ready) || (exp_ireq && !gnt)) && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
            if (pop_now)
                void'(m_fifo.pop_front());
            if (rvalid) begin
                p = m_out.pop_front();
                void'(mem_q.pop_front());
                if (!p.stale && !branch)
                    m_fifo.push_back('{pc: p.pc, instr: rdata});
            end
            if (exp_ireq && gnt) begin
                mem_q.push_back('{data: data_of(m_addr), due: cyc + int'($urandom_range(lat_max, lat_min))});
                m_out.push_back('{pc: m_addr, stale: 1'b0});
                m_addr = m_addr + 32'd4;
            end
            if (branch) begin
                m_fifo.delete();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_addr = {baddr[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b1; gnt = 1'b0; ready = 1'b0; branch = 1'b0;
        lat_min = 1; lat_max = 1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (obs_ireq !== 1'b0 || obs_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_valids got ireq=%b req=%b expected 0 0", obs_ireq, obs_req);
        end
        n_checks++;
        if (obs_data !== 32'h0 || obs_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_head got data=%h pc=%h expected 0 0", obs_data, obs_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (obs_stall !== 32'h0) begin
            n_fail++; $display("FAIL reset_stall got %0d expected 0", obs_stall);
        end
`endif
        gnt = 1'b1;
        cycle();
        n_checks++;
        if (obs_ireq !== 1'b1 || obs_addr !== 32'h80) begin
            n_fail++; $display("FAIL first_req got ireq=%b addr=%h expected 1 00000080", obs_ireq, obs_addr);
        end
        cycle();
        cycle();
        n_checks++;
        if (obs_req !== 1'b1 || obs_data !== 32'h6F || obs_pc !== 32'h80) begin
            n_fail++; $display("FAIL first_instr got req=%b data=%h pc=%h expected 1 0000006f 00000080",
                               obs_req, obs_data, obs_pc);
        end
    endtask

    task automatic test_streaming();
        reset_dut();
        gnt = 1'b1; ready = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 6; k++) begin
            logic [31:0] pc_k;
            pc_k = 32'h80 + 32'(4 * k);
            cycle();
            n_checks++;
            if (obs_req !== 1'b1 || obs_pc !== pc_k || obs_data !== data_of(pc_k)) begin
                n_fail++; $display("FAIL stream_%0d got req=%b pc=%h data=%h expected 1 %h %h",
                                   k, obs_req, obs_pc, obs_data, pc_k, data_of(pc_k));
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        gnt = 1'b1; ready = 1'b0;
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (obs_ireq !== 1'b0 || obs_req !== 1'b1 || obs_pc !== 32'h80) begin
                n_fail++; $display("FAIL hold_%0d got ireq=%b req=%b pc=%h expected 0 1 00000080",
                                   k, obs_ireq, obs_req, obs_pc);
            end
        end
        ready = 1'b1;
        cycle();
        n_checks++;
        if (obs_ireq !== 1'b1 || obs_addr !== 32'h88 || obs_pc !== 32'h80) begin
            n_fail++; $display("FAIL release got ireq=%b addr=%h pc=%h expected 1 00000088 00000080",
                               obs_ireq, obs_addr, obs_pc);
        end
        ready = 1'b0;
        cycle();
        n_checks++;
        if (obs_req !== 1'b1 || obs_pc !== 32'h84) begin
            n_fail++; $display("FAIL after_pop got req=%b pc=%h expected 1 00000084", obs_req, obs_pc);
        end
    endtask

    task automatic test_gnt_stall();
        reset_dut();
        ready = 1'b1; gnt = 1'b1;
        cycle();
        gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (obs_ireq !== 1'b1 || obs_addr !== 32'h84) begin
                n_fail++; $display("FAIL gnt_wait_%0d got ireq=%b addr=%h expected 1 00000084",
                                   k, obs_ireq, obs_addr);
            end
        end
        gnt = 1'b1;
        cycle();
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (obs_stall !== 32'd3) begin
            n_fail++; $display("FAIL stall_cnt got %0d expected 3", obs_stall);
        end
`endif
        n_checks++;
        if (obs_addr !== 32'h84) begin
            n_fail++; $display("FAIL gnt_resume got addr=%h expected 00000084", obs_addr);
        end
    endtask

    task automatic test_branch();
        reset_dut();
        ready = 1'b1; gnt = 1'b1; lat_min = 2; lat_max = 2;
        cycle();
        gnt = 1'b0; branch = 1'b1; baddr = 32'h0000_0103;
        cycle();
        branch = 1'b0; gnt = 1'b1;
        cycle();
        n_checks++;
        if (obs_ireq !== 1'b1 || obs_addr !== 32'h100) begin
            n_fail++; $display("FAIL branch_addr got ireq=%b addr=%h expected 1 00000100", obs_ireq, obs_addr);
        end
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_checks++;
            if (obs_req !== 1'b0) begin
                n_fail++; $display("FAIL stale_drop_%0d got req=%b expected 0", k, obs_req);
            end
        end
        cycle();
        n_checks++;
        if (obs_req !== 1'b1 || obs_pc !== 32'h100 || obs_data !== data_of(32'h100)) begin
            n_fail++; $display("FAIL branch_target got req=%b pc=%h data=%h expected 1 00000100 %h",
                               obs_req, obs_pc, obs_data, data_of(32'h100));
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_full();
        reset_dut();
        gnt = 1'b1; ready = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        n_checks++;
        if (obs_req !== 1'b0 || obs_ireq !== 1'b1 || obs_addr !== 32'h80) begin
            n_fail++; $display("FAIL reset_full got req=%b ireq=%b addr=%h expected 0 1 00000080",
                               obs_req, obs_ireq, obs_addr);
        end
    endtask

    task automatic test_random();
        reset_dut();
        lat_min = 1; lat_max = 3;
        for (int n = 0; n < 800; n++) begin
            rst    = ($urandom_range(199, 0) == 0);
            gnt    = ($urandom_range(9, 0) < 7);
            ready  = ($urandom_range(9, 0) < 6);
            branch = ($urandom_range(19, 0) == 0);
            baddr  = $urandom;
            cycle();
            n_checks++;
            if (obs_ireq !== exp_ireq || (exp_ireq && obs_addr !== exp_addr)) begin
                n_fail++; $display("FAIL rand_fetch cyc=%0d got ireq=%b addr=%h expected %b %h",
                                   cyc, obs_ireq, obs_addr, exp_ireq, exp_addr);
            end
            n_checks++;
            if (obs_req !== exp_req ||
                (exp_req && (obs_pc !== exp_head.pc || obs_data !== exp_head.instr))) begin
                n_fail++; $display("FAIL rand_decode cyc=%0d got req=%b pc=%h data=%h expected %b %h %h",
                                   cyc, obs_req, obs_pc, obs_data, exp_req, exp_head.pc, exp_head.instr);
            end
`ifdef FETCH_PERF_CNT_EN
            n_checks++;
            if (obs_stall !== exp_stall) begin
                n_fail++; $display("FAIL rand_stall cyc=%0d got %0d expected %0d", cyc, obs_stall, exp_stall);
            end
`endif
        end
        rst = 1'b0; branch = 1'b0;
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_streaming();
        test_backpressure();
        test_gnt_stall();
        test_branch();
        test_reset_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
